mips_avalon_arbiter: RTL and testbench

- Avalon memory-mapped master front-end between the MIPS core and the single-port Avalon memory slave.
- Takes two requester ports: instruction fetch (read-only) and data (read/write with byte enables).
- Arbitrates between them, drives exactly one Avalon transaction at a time and holds it stable under waitrequest.
- Returns read data to the winning requester with a one-cycle done pulse; watchdog flags a hung bus.

---
 rtl/mips_avalon_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mips_avalon_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_arbiter.sv
// Avalon-MM master front-end for the MIPS core: arbitrates the instruction
// fetch port and the data port onto a single Avalon slave, one transaction
// at a time, with a bus watchdog.
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of the default fixed priority (data over instruction).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; Avalon controls low; grant on any req
// BUSY  | transaction on the bus, held stable until waitrequest=0
// DONE  | one cycle; winner's done pulses, rdata valid, no arbitration
module mips_avalon_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam bit                 WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0]        ABORT_DATA = 32'hDEADBEEF;

  logic [1:0]           state;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [TIMEOUT_W-1:0] wd_next;
  logic                 wd_hit;
  logic                 gnt_d;
  logic                 pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_d;

  // Contested grant goes to the port not served last; otherwise the requester.
  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) begin
      pick_d = !last_gnt_d;
    end
  end

  // Last-grant register, starts as "instruction" so data wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_d <= 1'b0;
    end else if (state == ST_IDLE && (i_req || d_req)) begin
      last_gnt_d <= pick_d;
    end
  end
`else
  // Fixed priority: data always beats instruction fetch.
  always_comb begin
    pick_d = d_req;
  end
`endif

  assign wd_next = wd_cnt + 1'b1;
  assign wd_hit  = WD_EN && waitrequest && (wd_next == WD_LIMIT);

  // Main sequencer: grant, hold the transaction, report completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wd_cnt     <= '0;
      gnt_d      <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          if (i_req || d_req) begin
            state  <= ST_BUSY;
            wd_cnt <= '0;
            gnt_d  <= pick_d;
            if (pick_d) begin
              address    <= d_addr;
              writedata  <= d_wdata;
              byteenable <= d_be;
              read       <= !d_we;
              write      <= d_we;
            end else begin
              address    <= i_addr;
              writedata  <= '0;
              byteenable <= 4'hF;
              read       <= 1'b1;
              write      <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            state <= ST_DONE;
            if (gnt_d) begin
              d_done <= 1'b1;
              if (read) begin
                d_rdata <= readdata;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= readdata;
            end
          end else if (wd_hit) begin
            // Slave never answered: abandon the access and poison the data.
            read    <= 1'b0;
            write   <= 1'b0;
            bus_err <= 1'b1;
            wd_cnt  <= wd_next;
            state   <= ST_DONE;
            if (gnt_d) begin
              d_done  <= 1'b1;
              d_rdata <= ABORT_DATA;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= ABORT_DATA;
            end
          end else if (WD_EN) begin
            wd_cnt <= wd_next;
          end
        end
        ST_DONE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          read   <= 1'b0;
          write  <= 1'b0;
          i_done <= 1'b0;
          d_done <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter with a small Avalon slave model
// whose waitrequest latency is programmable per transaction.
module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .bus_err(bus_err)
  );

  // Slave model: waitrequest high for wait_lat cycles of each access, or forever when stuck.
  int          wait_lat = 0;
  bit          stuck = 1'b0;
  int          wcnt = 0;
  logic [31:0] mem [0:15];
  logic [31:0] log_q [$];

  assign waitrequest = stuck || ((read || write) && (wcnt < wait_lat));
  assign readdata    = mem[address[5:2]];

  always @(posedge clk) begin
    if ((read || write) && waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if ((read || write) && !waitrequest) log_q.push_back(address);
    if (write && !waitrequest) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // Bus monitor sampled between edges.
  int   starts = 0, rw_cycles = 0, overlap = 0, dones = 0;
  logic prev_rw = 1'b0;
  always @(negedge clk) begin
    if ((read || write) && !prev_rw) starts++;
    if (read || write) rw_cycles++;
    if (read && write) overlap++;
    if (i_done || d_done) dones++;
    prev_rw = read || write;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (i_done || d_done) begin
        cyc = n;
        break;
      end
    end
  endtask

  int         cyc;
  int         base;
  logic [3:0] ord;

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    mem[0] = 32'h3C011234;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    step(); step();
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_dones", {i_done, d_done}, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 1'b0;
    step();

    // Fetch with two wait cycles
    wait_lat = 2;
    i_addr = 32'hBFC00000; i_req = 1'b1;
    step();
    chk("fetch_read", read, 1);
    chk("fetch_addr", address, 32'hBFC00000);
    chk("fetch_be", byteenable, 4'hF);
    chk("fetch_write", write, 0);
    step();
    chk("fetch_hold", {read, address}, {1'b1, 32'hBFC00000});
    wait_done(20, cyc);
    chk("fetch_latency", 32'(cyc), 2);
    chk("fetch_i_done", i_done, 1);
    chk("fetch_d_done", d_done, 0);
    chk("fetch_rdata", i_rdata, 32'h3C011234);
    chk("fetch_done_read", read, 0);
    i_req = 1'b0;
    step();
    chk("fetch_done_pulse", i_done, 0);

    // Byte write then read back
    wait_lat = 1;
    d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hAABBCCDD; d_be = 4'b0010; d_req = 1'b1;
    step();
    chk("wr_rw", {read, write}, 2'b01);
    chk("wr_be", byteenable, 4'b0010);
    chk("wr_data", writedata, 32'hAABBCCDD);
    chk("wr_addr", address, 32'h10);
    wait_done(20, cyc);
    chk("wr_latency", 32'(cyc), 2);
    chk("wr_d_done", {d_done, i_done, write}, 3'b100);
    d_req = 1'b0;
    step();
    d_we = 1'b0; d_req = 1'b1;
    wait_done(20, cyc);
    chk("rd_latency", 32'(cyc), 3);
    chk("rd_d_rdata", d_rdata, 32'h0000CC00);
    d_req = 1'b0;
    step();

    // Contention: data first, then fetch
    wait_lat = 0;
    log_q.delete();
    base = starts;
    i_req = 1'b1; d_req = 1'b1;
    wait_done(20, cyc);
    chk("cont_first_lat", 32'(cyc), 2);
    chk("cont_first_dd", {d_done, i_done}, 2'b10);
    chk("cont_first_data", d_rdata, 32'h0000CC00);
    d_req = 1'b0;
    wait_done(20, cyc);
    chk("cont_second_lat", 32'(cyc), 3);
    chk("cont_second_dd", {d_done, i_done}, 2'b01);
    chk("cont_second_data", i_rdata, 32'h3C011234);
    i_req = 1'b0;
    step();
    chk("cont_txn_count", 32'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("cont_order0", log_q[0], 32'h10);
      chk("cont_order1", log_q[1], 32'hBFC00000);
    end
    chk("cont_starts", 32'(starts - base), 2);

    // Grant order with both requests held after reset
    rst = 1'b1; step(); step(); rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    ord = '0;
    for (int k = 0; k < 4; k++) begin
      wait_done(20, cyc);
      ord[k] = d_done;
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
`ifdef ARB_ROUND_ROBIN_EN
    chk("grant_order", ord, 4'b0101);
`else
    chk("grant_order", ord, 4'b1111);
`endif

    // Watchdog abort on a hung slave
    stuck = 1'b1;
    base = rw_cycles;
    i_req = 1'b1;
    wait_done(40, cyc);
    chk("wd_latency", 32'(cyc), 9);
    chk("wd_read_cycles", 32'(rw_cycles - base), 8);
    chk("wd_rdata", i_rdata, 32'hDEADBEEF);
    chk("wd_i_done", i_done, 1);
    chk("wd_bus_err", bus_err, 1);
    chk("wd_read_low", read, 0);
    i_req = 1'b0; stuck = 1'b0;
    step();
    i_req = 1'b1;
    wait_done(20, cyc);
    chk("wd_recover_data", i_rdata, 32'h3C011234);
    chk("wd_sticky", bus_err, 1);
    i_req = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("wd_cleared", bus_err, 0);

    // Reset in the middle of a BUSY wait
    wait_lat = 5;
    base = dones;
    i_req = 1'b1;
    step();
    step();
    rst = 1'b1; i_req = 1'b0;
    step();
    chk("mid_rst_read", read, 0);
    chk("mid_rst_done", i_done, 0);
    rst = 1'b0;
    step(); step();
    chk("mid_rst_no_done", 32'(dones - base), 0);
    chk("mid_rst_idle", read, 0);
    wait_lat = 0;
    i_req = 1'b1;
    wait_done(20, cyc);
    chk("post_rst_lat", 32'(cyc), 2);
    chk("post_rst_data", {i_done, i_rdata}, {1'b1, 32'h3C011234});
    i_req = 1'b0;
    step();

    chk("rw_overlap", 32'(overlap), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
